addr_exc_unit: RTL and testbench
================================

Name: addr_exc_unit

Overview:
- Producer side of the CP0 BadVAddr interface: detects misaligned instruction-fetch and data accesses.
- Emits a one-cycle addr_err pulse together with the faulting virtual address on badvaddr_p, which the BadVAddr capture unit latches.
- Also owns the exception sequencing for address errors: pipeline flush, redirect to the exception vector, and return on ERET. Provides EPC and the cause exception code.
- Sits between the fetch/MEM pipeline stages and the CP0 register units.

Parameters:
- FLUSH_CYCLES, 2, cycles flush is held high after an error is accepted (1..15).
- EXC_VECTOR, 32'hBFC00380, general exception vector driven on redirect_pc.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset.
- if_valid  in  1  fetch address valid this cycle.
- if_pc  in  32  fetch virtual address.
- mem_valid  in  1  data access valid this cycle.
- mem_we  in  1  1=store, 0=load.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_addr  in  32  data virtual address.
- mem_pc  in  32  PC of the instruction in MEM.
- user_mode  in  1  current privilege (used only with the optional feature).
- eret  in  1  ERET committing this cycle.
- addr_err  out  1  one-cycle pulse; load enable for BadVAddr.
- badvaddr_p  out  32  faulting address, valid while addr_err=1.
- exc_code  out  5  4=AdEL, 5=AdES; holds its last value.
- epc  out  32  exception PC.
- exl  out  1  exception level active.
- flush  out  1  pipeline flush request.
- redirect  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  32  target while redirect=1.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - addr_err, flush, redirect and exl are 0.
  - badvaddr_p, epc and redirect_pc are 0.
  - exc_code is 0.
  - Reset overrides all other inputs, including mid-sequence.
- Detection (combinational, sampled at the clk edge):
  - fetch error = if_valid & (if_pc[1:0]!=0).
  - data error = mem_valid & ((size half & addr[0]) | (size word/11 & addr[1:0]!=0)).
  - Data (older instruction) has priority over fetch when both occur in the same cycle.
- Error accepted in IDLE or IN_EXC (registered, 1-cycle latency):
  - Next cycle: addr_err=1, with badvaddr_p = mem_addr (data) or if_pc (fetch).
  - exc_code = 5 if data error & mem_we, else 4.
  - epc = mem_pc (data) or if_pc (fetch), updated only if exl was 0; nested errors keep epc.
  - exl is set to 1.
  - state moves to FLUSH.
- FSM states: IDLE, FLUSH, REDIRECT, IN_EXC.
  - FLUSH: flush=1 for exactly FLUSH_CYCLES cycles (counter), then go to REDIRECT. Errors and eret are ignored.
  - REDIRECT: redirect=1 and redirect_pc=EXC_VECTOR for one cycle, then go to IN_EXC. Errors and eret are ignored.
  - IN_EXC: an error restarts the sequence (goes to FLUSH, epc held). Otherwise eret=1 gives redirect=1, redirect_pc=epc and exl=0 in the next cycle, and state returns to IDLE.
  - Error and eret in the same IN_EXC cycle: the error wins and eret is dropped.
  - eret in IDLE is ignored.
- addr_err never stays high for two consecutive cycles. badvaddr_p holds its last value when addr_err=0.

Optional Feature:
- ADDR_SEG_CHECK_EN defined: when user_mode=1, an address with bit31=1 (kseg) is an address error for both fetch and data, even if aligned. It follows the same priority, codes and sequence as a misalignment error.
- Undefined: only alignment is checked and user_mode is unused.

Decomposition:
- Shared head package gets:
  - EXC_ADEL=5'd4 and EXC_ADES=5'd5.
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state encodings.
  - Existing ENABLE/DISABLE constants.
- One natural sub-module: addr_align_chk, purely combinational. It takes addr, size and user_mode and returns err. It is instantiated twice, for fetch (size fixed to word) and data.

Test Plan:
- Load word, mem_addr=32'h00001002, mem_pc=32'h80000100 -> next cycle addr_err=1, badvaddr_p=32'h00001002, exc_code=4, epc=32'h80000100; flush high 2 cycles, then redirect with redirect_pc=32'hBFC00380.
- Store half, mem_addr=32'h00002001 -> exc_code=5, badvaddr_p=32'h00002001; store byte to the same address -> no error.
- Same cycle: if_pc=32'h80000202 and data error at 32'h00000003 -> badvaddr_p=32'h00000003, epc=mem_pc.
- In IN_EXC, fetch error at 32'hBFC00381 -> addr_err pulses, badvaddr_p updates, epc unchanged, sequence restarts. Then eret -> redirect_pc=original epc, exl=0.
- rst=0 during FLUSH -> next cycle all outputs 0 and state IDLE; a subsequent aligned access raises no error.
- With ADDR_SEG_CHECK_EN, user_mode=1, load word at 32'h80000000 -> exc_code=4; with user_mode=0 -> no error.

Source files
------------

// File: rtl/addr_exc_unit_pkg.sv
// addr_exc_unit_pkg: shared constants, size encodings and FSM states for the address-error unit
package addr_exc_unit_pkg;
    localparam logic ENABLE = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT, S_IN_EXC} state_t;
endpackage

// File: rtl/addr_exc_unit_if.sv
// addr_exc_unit_if: pipeline-side inputs and CP0/fetch-side outputs of the address-error unit
interface addr_exc_unit_if;
    logic if_valid;
    logic [31:0] if_pc;
    logic mem_valid;
    logic mem_we;
    logic [1:0] mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_pc;
    logic user_mode;
    logic eret;
    logic addr_err;
    logic [31:0] badvaddr_p;
    logic [4:0] exc_code;
    logic [31:0] epc;
    logic exl;
    logic flush;
    logic redirect;
    logic [31:0] redirect_pc;
    modport master (
        output if_valid, if_pc, mem_valid, mem_we, mem_size, mem_addr, mem_pc, user_mode, eret,
        input addr_err, badvaddr_p, exc_code, epc, exl, flush, redirect, redirect_pc
    );
    modport slave (
        input if_valid, if_pc, mem_valid, mem_we, mem_size, mem_addr, mem_pc, user_mode, eret,
        output addr_err, badvaddr_p, exc_code, epc, exl, flush, redirect, redirect_pc
    );
endinterface

// File: rtl/addr_exc_unit_addr_align_chk.sv
// addr_align_chk: combinational misalignment check; with ADDR_SEG_CHECK_EN also flags user access to kseg
module addr_align_chk
    import addr_exc_unit_pkg::*;
(
    input logic [31:0] addr,
    input logic [1:0] size,
    input logic user_mode,
    output logic err
);
    logic mis;
    logic unused_bits;
    assign mis = (size == SZ_BYTE) ? 1'b0 : (size == SZ_HALF) ? addr[0] : |addr[1:0];
`ifdef ADDR_SEG_CHECK_EN
    assign err = mis | (user_mode & addr[31]);
    assign unused_bits = ^addr[30:2];
`else
    assign err = mis;
    assign unused_bits = ^{user_mode, addr[31:2]};
`endif
endmodule

// File: rtl/addr_exc_unit.sv
// addr_exc_unit: address-error detection, BadVAddr pulse and flush/redirect/ERET sequencing
// Optional kseg-in-user-mode check enabled by defining ADDR_SEG_CHECK_EN.
module addr_exc_unit
    import addr_exc_unit_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input logic clk,
    input logic rst,
    addr_exc_unit_if.slave bus
);
    state_t state;
    logic [3:0] cnt;
    logic f_chk, d_chk, f_err, d_err, accept;
    addr_align_chk u_fetch_chk (.addr(bus.if_pc), .size(SZ_WORD), .user_mode(bus.user_mode), .err(f_chk));
    addr_align_chk u_data_chk (.addr(bus.mem_addr), .size(bus.mem_size), .user_mode(bus.user_mode), .err(d_chk));
    assign f_err = bus.if_valid & f_chk;
    assign d_err = bus.mem_valid & d_chk;
    assign accept = (state == S_IDLE || state == S_IN_EXC) && (f_err || d_err);
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt <= '0;
            bus.addr_err <= 1'b0;
            bus.badvaddr_p <= '0;
            bus.exc_code <= '0;
            bus.epc <= '0;
            bus.exl <= 1'b0;
            bus.flush <= 1'b0;
            bus.redirect <= 1'b0;
            bus.redirect_pc <= '0;
        end else begin
            bus.addr_err <= 1'b0;
            bus.redirect <= 1'b0;
            if (accept) begin
                bus.addr_err <= 1'b1;
                bus.badvaddr_p <= d_err ? bus.mem_addr : bus.if_pc;
                bus.exc_code <= (d_err && bus.mem_we) ? EXC_ADES : EXC_ADEL;
                if (!bus.exl) bus.epc <= d_err ? bus.mem_pc : bus.if_pc;
                bus.exl <= 1'b1;
                bus.flush <= 1'b1;
                cnt <= 4'(FLUSH_CYCLES - 1);
                state <= S_FLUSH;
            end else begin
                case (state)
                    S_FLUSH: begin
                        if (cnt == '0) begin
                            bus.flush <= 1'b0;
                            bus.redirect <= 1'b1;
                            bus.redirect_pc <= EXC_VECTOR;
                            state <= S_REDIRECT;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_REDIRECT: state <= S_IN_EXC;
                    S_IN_EXC: begin
                        if (bus.eret) begin
                            bus.redirect <= 1'b1;
                            bus.redirect_pc <= bus.epc;
                            bus.exl <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_addr_exc_unit.sv
// tb_addr_exc_unit: directed stimulus, cycle-by-cycle reference model compare plus literal checkpoints
module tb_addr_exc_unit;
    localparam int FC = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    addr_exc_unit_if bus ();
    addr_exc_unit #(.FLUSH_CYCLES(FC), .EXC_VECTOR(VEC)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: busy counts the remaining flush+redirect cycles after an accepted error.
    int busy = 0;
    bit m_valid = 0, m_err = 0, m_exl = 0, m_eret_red = 0;
    logic [31:0] m_bad = 0, m_epc = 0, m_rpc = 0;
    logic [4:0] m_code = 0;
    function automatic bit data_bad();
        bit e;
        e = bus.mem_size == 2'd0 ? 1'b0 : bus.mem_size == 2'd1 ? (bus.mem_addr % 2 != 0) : (bus.mem_addr % 4 != 0);
`ifdef ADDR_SEG_CHECK_EN
        e = e || (bus.user_mode && bus.mem_addr >= 32'h80000000);
`endif
        return bus.mem_valid && e;
    endfunction
    function automatic bit fetch_bad();
        bit e;
        e = bus.if_pc % 4 != 0;
`ifdef ADDR_SEG_CHECK_EN
        e = e || (bus.user_mode && bus.if_pc >= 32'h80000000);
`endif
        return bus.if_valid && e;
    endfunction
    always @(posedge clk) begin
        bit de, fe;
        de = data_bad();
        fe = fetch_bad();
        m_err = 0;
        m_eret_red = 0;
        if (!rst) begin
            m_valid = 1; busy = 0; m_exl = 0; m_epc = 0; m_bad = 0; m_code = 0; m_rpc = 0;
        end else if (busy == 0 && (de || fe)) begin
            m_err = 1;
            m_bad = de ? bus.mem_addr : bus.if_pc;
            m_code = (de && bus.mem_we) ? 5'd5 : 5'd4;
            if (!m_exl) m_epc = de ? bus.mem_pc : bus.if_pc;
            m_exl = 1;
            busy = FC + 1;
        end else if (busy > 0) begin
            busy--;
            if (busy == 1) m_rpc = VEC;
        end else if (m_exl && bus.eret) begin
            m_eret_red = 1;
            m_rpc = m_epc;
            m_exl = 0;
        end
    end
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_addr_err", bus.addr_err, m_err);
            chk("m_flush", bus.flush, busy > 1);
            chk("m_redirect", bus.redirect, busy == 1 || m_eret_red);
            chk("m_exl", bus.exl, m_exl);
            chk("m_epc", bus.epc, m_epc);
            chk("m_exc_code", bus.exc_code, m_code);
            chk("m_badvaddr", bus.badvaddr_p, m_bad);
            chk("m_redirect_pc", bus.redirect_pc, m_rpc);
        end
    end

    task automatic drive(input logic iv, input logic [31:0] ipc, input logic mv, input logic we,
                         input logic [1:0] sz, input logic [31:0] ma, input logic [31:0] mp,
                         input logic um, input logic er);
        bus.if_valid = iv; bus.if_pc = ipc; bus.mem_valid = mv; bus.mem_we = we;
        bus.mem_size = sz; bus.mem_addr = ma; bus.mem_pc = mp; bus.user_mode = um; bus.eret = er;
    endtask
    task automatic idle();
        drive(0, 32'h0, 0, 0, 2'd2, 32'h0, 32'h0, 0, 0);
    endtask
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask
    task automatic leave_exc();
        idle();
        tick(3);
        bus.eret = 1;
        tick();
        idle();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        idle();
        tick(2);
        chk("rst_addr_err", bus.addr_err, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_epc", bus.epc, 0);
        chk("rst_exc_code", bus.exc_code, 0);
        rst = 1;
        tick();
        bus.eret = 1;
        tick();
        chk("eret_idle_redirect", bus.redirect, 0);
        drive(0, 32'h0, 1, 0, 2'd2, 32'h00001002, 32'h80000100, 0, 0);
        tick();
        idle();
        chk("lw_addr_err", bus.addr_err, 1);
        chk("lw_badvaddr", bus.badvaddr_p, 32'h00001002);
        chk("lw_code", bus.exc_code, 4);
        chk("lw_epc", bus.epc, 32'h80000100);
        chk("lw_flush1", bus.flush, 1);
        tick();
        chk("lw_flush2", bus.flush, 1);
        chk("lw_pulse_once", bus.addr_err, 0);
        tick();
        chk("lw_flush_done", bus.flush, 0);
        chk("lw_redirect", bus.redirect, 1);
        chk("lw_vector", bus.redirect_pc, 32'hBFC00380);
        tick();
        bus.eret = 1;
        tick();
        idle();
        chk("eret_redirect", bus.redirect, 1);
        chk("eret_pc", bus.redirect_pc, 32'h80000100);
        chk("eret_exl", bus.exl, 0);
        tick();
        drive(0, 32'h0, 1, 1, 2'd1, 32'h00002001, 32'h80000110, 0, 0);
        tick();
        chk("sh_code", bus.exc_code, 5);
        chk("sh_badvaddr", bus.badvaddr_p, 32'h00002001);
        leave_exc();
        drive(0, 32'h0, 1, 1, 2'd0, 32'h00002001, 32'h80000120, 0, 0);
        tick();
        chk("sb_no_err", bus.addr_err, 0);
        drive(1, 32'h80000202, 1, 0, 2'd2, 32'h00000003, 32'h80000300, 0, 0);
        tick();
        idle();
        chk("both_badvaddr", bus.badvaddr_p, 32'h00000003);
        chk("both_epc", bus.epc, 32'h80000300);
        tick(3);
        drive(1, 32'hBFC00381, 0, 0, 2'd2, 32'h0, 32'h0, 0, 1);
        tick();
        chk("nest_addr_err", bus.addr_err, 1);
        chk("nest_badvaddr", bus.badvaddr_p, 32'hBFC00381);
        chk("nest_epc", bus.epc, 32'h80000300);
        chk("nest_no_eret", bus.redirect, 0);
        idle();
        tick(3);
        bus.eret = 1;
        tick();
        idle();
        chk("nest_eret_pc", bus.redirect_pc, 32'h80000300);
        chk("nest_eret_exl", bus.exl, 0);
        tick();
        drive(1, 32'h80000402, 0, 0, 2'd2, 32'h0, 32'h0, 0, 0);
        tick();
        idle();
        chk("fetch_epc", bus.epc, 32'h80000402);
        rst = 0;
        tick();
        rst = 1;
        chk("midrst_flush", bus.flush, 0);
        chk("midrst_exl", bus.exl, 0);
        chk("midrst_epc", bus.epc, 0);
        chk("midrst_badvaddr", bus.badvaddr_p, 0);
        drive(1, 32'h80000400, 1, 0, 2'd2, 32'h00001000, 32'h80000404, 0, 0);
        tick();
        chk("aligned_no_err", bus.addr_err, 0);
        drive(0, 32'h0, 1, 0, 2'd2, 32'h80000000, 32'h80000500, 0, 0);
        tick();
        chk("kseg_kernel_no_err", bus.addr_err, 0);
        drive(0, 32'h0, 1, 0, 2'd2, 32'h80000000, 32'h80000500, 1, 0);
        tick();
`ifdef ADDR_SEG_CHECK_EN
        chk("kseg_user_err", bus.addr_err, 1);
        chk("kseg_user_code", bus.exc_code, 4);
        leave_exc();
`else
        chk("kseg_user_no_err", bus.addr_err, 0);
        idle();
        tick();
`endif
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
